// File: rtl/fpadd_control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpadd_control_pipe
// Purpose  : Sequencing controller for the floating-point adder datapath:
//            alignment, normalisation, bounded rounding loop, result handshake.
// Options  : FPCTL_EQEXP_BYPASS_EN - equal exponents skip the ALIGN state.
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_control_pipe #(
    parameter  int EXPBITS      = 8,
    parameter  int MANTISSABITS = 23,
    parameter  int MAXROUND     = 3,
    localparam int NBITS        = $clog2(MANTISSABITS + 2),
    localparam int NBITSE       = $clog2(MANTISSABITS + 3)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Go,
    input  logic                    ExpSet,
    input  logic [EXPBITS-1:0]      ExpDiff,
    input  logic                    FFOValid,
    input  logic [NBITS-1:0]        FFOIndex,
    input  logic [MANTISSABITS+1:0] roundedMant,
    input  logic                    ResultReady,
    output logic                    Busy,
    output logic                    SelExpMux,
    output logic                    SelSRMuxL,
    output logic                    SelSRMuxG,
    output logic                    ShiftRightEnable,
    output logic [NBITSE-1:0]       ShiftRightAmount,
    output logic [NBITS-1:0]        ShiftAmount,
    output logic                    SREn,
    output logic                    SLEn,
    output logic                    NoShift,
    output logic                    SelMuxR,
    output logic                    ResultValid,
    output logic                    FlagResult,
    output logic                    RoundErr
);

    localparam int C_SATAMT = MANTISSABITS + 2;
    localparam int C_CNTW   = (MAXROUND < 1) ? 1 : $clog2(MAXROUND + 1);
    localparam int C_CMPW   = ((EXPBITS > NBITSE) ? EXPBITS : NBITSE) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_expset;
    logic [EXPBITS-1:0]  r_expdiff;
    logic [C_CNTW-1:0]   r_cnt;
    logic                r_flag;
    logic                r_rerr;
    logic                w_flag_set;
    logic                w_rerr_set;
    logic                w_cnt_inc;
    logic                w_bypass;
    logic                w_sat;
    logic                w_unused_mant;

    // Only the carry-out bit of the rounder matters to sequencing.
    assign w_unused_mant = ^roundedMant[MANTISSABITS:0];

`ifdef FPCTL_EQEXP_BYPASS_EN
    assign w_bypass = (ExpDiff == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Compare in a width that holds both operands so large differences saturate.
    assign w_sat = (C_CMPW'(r_expdiff) > C_CMPW'(C_SATAMT));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_expset  <= 1'b0;
            r_expdiff <= '0;
            r_cnt     <= '0;
            r_flag    <= 1'b0;
            r_rerr    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && Go) begin
                r_expset  <= ExpSet;
                r_expdiff <= ExpDiff;
            end
            if (r_state == S_NORM) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Result flags freeze on entry to DONE and hold through backpressure.
            if (r_state != S_DONE) begin
                r_flag <= w_flag_set;
                r_rerr <= w_rerr_set;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_flag_set       = 1'b0;
        w_rerr_set       = 1'b0;
        w_cnt_inc        = 1'b0;
        SelExpMux        = 1'b0;
        SelSRMuxL        = 1'b0;
        SelSRMuxG        = 1'b0;
        ShiftRightEnable = 1'b0;
        ShiftRightAmount = '0;
        ShiftAmount      = '0;
        SREn             = 1'b0;
        SLEn             = 1'b0;
        NoShift          = 1'b0;
        SelMuxR          = 1'b0;
        ResultValid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Go) begin
                    w_next = w_bypass ? S_NORM : S_ALIGN;
                end
            end
            S_ALIGN: begin
                SelExpMux        = r_expset;
                SelSRMuxL        = r_expset;
                SelSRMuxG        = ~r_expset;
                ShiftRightEnable = (r_expdiff != '0);
                ShiftRightAmount = w_sat ? NBITSE'(C_SATAMT) : NBITSE'(r_expdiff);
                w_next           = S_NORM;
            end
            S_NORM: begin
                w_next = S_ROUND;
                if (!FFOValid) begin
                    w_flag_set = 1'b1;
                    w_next     = S_DONE;
                end else if (FFOIndex == NBITS'(MANTISSABITS + 1)) begin
                    SREn        = 1'b1;
                    ShiftAmount = NBITS'(1);
                end else if (FFOIndex == NBITS'(MANTISSABITS)) begin
                    NoShift = 1'b1;
                end else if (FFOIndex < NBITS'(MANTISSABITS)) begin
                    SLEn        = 1'b1;
                    ShiftAmount = NBITS'(MANTISSABITS) - FFOIndex;
                end else begin
                    w_rerr_set = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_ROUND: begin
                if (roundedMant[MANTISSABITS+1]) begin
                    if (r_cnt < C_CNTW'(MAXROUND)) begin
                        SREn        = 1'b1;
                        ShiftAmount = NBITS'(1);
                        SelMuxR     = 1'b1;
                        w_cnt_inc   = 1'b1;
                    end else begin
                        w_rerr_set = 1'b1;
                        w_next     = S_DONE;
                    end
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                ResultValid = 1'b1;
                if (ResultReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        FlagResult = w_flag_set | ((r_state == S_DONE) & r_flag);
        RoundErr   = w_rerr_set | ((r_state == S_DONE) & r_rerr);
        Busy       = (r_state != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_fpadd_control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpadd_control_pipe
// Purpose  : Self-checking bench: per-operation cycle script from a behavioural
//            model, randomized operations, directed boundary cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpadd_control_pipe;

    localparam int EXPBITS  = 8;
    localparam int MB       = 23;
    localparam int MAXROUND = 3;
    localparam int NBITS    = $clog2(MB + 2);
    localparam int NBITSE   = $clog2(MB + 3);
    localparam int MW       = MB + 2;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Go;
    logic               ExpSet;
    logic [EXPBITS-1:0] ExpDiff;
    logic               FFOValid;
    logic [NBITS-1:0]   FFOIndex;
    logic [MW-1:0]      roundedMant;
    logic               ResultReady;
    logic               Busy, SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable;
    logic [NBITSE-1:0]  ShiftRightAmount;
    logic [NBITS-1:0]   ShiftAmount;
    logic               SREn, SLEn, NoShift, SelMuxR, ResultValid, FlagResult, RoundErr;

    fpadd_control_pipe #(
        .EXPBITS(EXPBITS), .MANTISSABITS(MB), .MAXROUND(MAXROUND)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
        .FFOValid(FFOValid), .FFOIndex(FFOIndex), .roundedMant(roundedMant),
        .ResultReady(ResultReady), .Busy(Busy), .SelExpMux(SelExpMux),
        .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
        .ShiftRightEnable(ShiftRightEnable), .ShiftRightAmount(ShiftRightAmount),
        .ShiftAmount(ShiftAmount), .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift),
        .SelMuxR(SelMuxR), .ResultValid(ResultValid), .FlagResult(FlagResult),
        .RoundErr(RoundErr)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic              busy, selexp, selsrl, selsrg, sre;
        logic [NBITSE-1:0] sra;
        logic [NBITS-1:0]  sa;
        logic              sren, slen, noshift, selmuxr, rv, flag, rerr;
    } outs_t;

    typedef struct {
        int                 op;
        logic               go, es;
        logic [EXPBITS-1:0] ed;
        logic               fv;
        logic [NBITS-1:0]   fi;
        logic [MW-1:0]      rm;
        logic               rdy;
        outs_t              eo;
    } cyc_t;

    cyc_t  q[$];
    int    n_chk = 0, n_pass = 0;
    int    lat_exp = -1, lat = 0, op_id = 0, cur_op = 0;
    bit    chk_en = 1'b0, prev_busy = 1'b0, prev_rv = 1'b0;
    outs_t exp_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{Busy, SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
              ShiftAmount, SREn, SLEn, NoShift, SelMuxR, ResultValid, FlagResult, RoundErr};
        return o;
    endfunction

    // Model rules: saturated alignment distance, left-normalise distance.
    function automatic int sat_amt(input int ed);
        return (ed > MB + 2) ? MB + 2 : ed;
    endfunction

    function automatic int norm_left(input int fi);
        return MB - fi;
    endfunction

    function automatic logic [MW-1:0] rnd_mant(input logic msb);
        logic [MW-1:0] m;
        m = MW'($urandom);
        m[MW-1] = msb;
        return m;
    endfunction

    task automatic push(input logic go, input logic es, input logic [EXPBITS-1:0] ed,
                        input logic fv, input logic [NBITS-1:0] fi, input logic [MW-1:0] rm,
                        input logic rdy, input outs_t o);
        cyc_t c;
        c.op = op_id; c.go = go; c.es = es; c.ed = ed; c.fv = fv; c.fi = fi;
        c.rm = rm; c.rdy = rdy; c.eo = o;
        q.push_back(c);
    endtask

    // Inputs not consumed in a given cycle are randomized to prove they are ignored.
    task automatic push_junk(input logic go, input logic rdy, input outs_t o);
        push(go, 1'($urandom), EXPBITS'($urandom), 1'($urandom), NBITS'($urandom),
             rnd_mant(1'($urandom)), rdy, o);
    endtask

    // Expected cycle-by-cycle script for one operation; 'ones' = leading carry-outs.
    task automatic build_op(input logic es, input logic [EXPBITS-1:0] ed, input logic fv,
                            input logic [NBITS-1:0] fi, input int ones, input int stall,
                            input int gap);
        outs_t o;
        bit    err, bypass;
        op_id++;
        err    = 1'b0;
        bypass = 1'b0;
`ifdef FPCTL_EQEXP_BYPASS_EN
        bypass = (ed == 0);
`endif
        o = '0;
        push(1'b1, es, ed, 1'($urandom), NBITS'($urandom), rnd_mant(1'($urandom)),
             1'($urandom), o);
        if (!bypass) begin
            o = '0; o.busy = 1'b1;
            o.selexp = es; o.selsrl = es; o.selsrg = ~es;
            o.sre = (ed != 0);
            o.sra = NBITSE'(sat_amt(int'(ed)));
            push_junk(1'($urandom), 1'($urandom), o);
        end
        o = '0; o.busy = 1'b1;
        if (!fv)                 o.flag = 1'b1;
        else if (fi == MB + 1)   begin o.sren = 1'b1; o.sa = NBITS'(1); end
        else if (fi == MB)       o.noshift = 1'b1;
        else if (int'(fi) < MB)  begin o.slen = 1'b1; o.sa = NBITS'(norm_left(int'(fi))); end
        else                     begin o.rerr = 1'b1; err = 1'b1; end
        push(1'($urandom), 1'($urandom), EXPBITS'($urandom), fv, fi,
             rnd_mant(1'($urandom)), 1'($urandom), o);
        if (fv && !err) begin
            for (int k = 0; k <= MAXROUND; k++) begin
                o = '0; o.busy = 1'b1;
                if (k < ones && k < MAXROUND) begin
                    o.sren = 1'b1; o.sa = NBITS'(1); o.selmuxr = 1'b1;
                    push(1'($urandom), 1'($urandom), EXPBITS'($urandom), 1'($urandom),
                         NBITS'($urandom), rnd_mant(1'b1), 1'($urandom), o);
                end else begin
                    if (k < ones) begin o.rerr = 1'b1; err = 1'b1; end
                    push(1'($urandom), 1'($urandom), EXPBITS'($urandom), 1'($urandom),
                         NBITS'($urandom), rnd_mant(k < ones), 1'($urandom), o);
                    break;
                end
            end
        end
        for (int s = 0; s <= stall; s++) begin
            o = '0; o.busy = 1'b1; o.rv = 1'b1; o.flag = ~fv; o.rerr = err;
            push_junk(1'($urandom), (s == stall), o);
        end
        for (int g = 0; g < gap; g++) begin
            o = '0;
            push_junk(1'b0, 1'($urandom), o);
        end
    endtask

    task automatic run_queue(input int limit);
        int n;
        n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge Clock);
            Go = c.go; ExpSet = c.es; ExpDiff = c.ed; FFOValid = c.fv; FFOIndex = c.fi;
            roundedMant = c.rm; ResultReady = c.rdy; exp_cur = c.eo; cur_op = c.op;
            chk_en = 1'b1;
            n++;
        end
        if (limit < 0) begin
            @(negedge Clock);
            chk_en = 1'b0; Go = 1'b0; ResultReady = 1'b0;
        end
        q.delete();
    endtask

    always @(negedge Clock) begin
        #2;
        if (chk_en) begin
            check($sformatf("outputs op%0d", cur_op), 64'(dut_outs()), 64'(exp_cur));
            if (Busy && !prev_busy) lat = 0;
            else if (Busy) lat++;
            if (ResultValid && !prev_rv && lat_exp >= 0)
                check($sformatf("latency op%0d", cur_op), 64'(lat), 64'(lat_exp));
            prev_busy = Busy;
            prev_rv   = ResultValid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Go = 1'b0; ExpSet = 1'b0; ExpDiff = '0; FFOValid = 1'b0;
        FFOIndex = '0; roundedMant = '0; ResultReady = 1'b0;
        repeat (2) @(negedge Clock);
        #1 check("reset_outputs", 64'(dut_outs()), 64'(0));
        Reset = 1'b0;

        check("pin_sat_0x55", 64'(sat_amt(8'h55)), 64'(25));
        check("pin_sat_3", 64'(sat_amt(3)), 64'(3));
        check("pin_norm_20", 64'(norm_left(20)), 64'(3));

        // Saturated alignment, no shift, no rounding pass
        lat_exp = 3; build_op(1'b1, 8'h55, 1'b1, NBITS'(23), 0, 0, 0); run_queue(-1);
        // Left normalise by 3, one rounding pass
        lat_exp = 4; build_op(1'b0, 8'd3, 1'b1, NBITS'(20), 1, 0, 0); run_queue(-1);
        // Zero result held under backpressure, then one idle cycle
        lat_exp = 2; build_op(1'b1, 8'd4, 1'b0, NBITS'(0), 0, 5, 1); run_queue(-1);
        // Carry-out persists past MAXROUND passes
        lat_exp = 3 + MAXROUND; build_op(1'b1, 8'd2, 1'b1, NBITS'(24), MAXROUND + 1, 1, 0);
        run_queue(-1);
        // Exactly MAXROUND passes is still legal
        lat_exp = 3 + MAXROUND; build_op(1'b0, 8'd26, 1'b1, NBITS'(0), MAXROUND, 0, 0);
        run_queue(-1);
        // Illegal leading-one index
        lat_exp = 2; build_op(1'b0, 8'd1, 1'b1, NBITS'(30), 0, 0, 0); run_queue(-1);

        // Reset during the second rounding pass
        lat_exp = -1;
        build_op(1'b1, 8'd5, 1'b1, NBITS'(23), MAXROUND + 1, 0, 0);
        run_queue(5);
        #3 Reset = 1'b1; chk_en = 1'b0;
        #1 check("reset_mid_round_outputs", 64'(dut_outs()), 64'(0));
        check("reset_mid_round_busy", 64'(Busy), 64'(0));
        @(negedge Clock); Reset = 1'b0; Go = 1'b0;
        lat_exp = 3; build_op(1'b0, 8'd7, 1'b1, NBITS'(24), 0, 0, 0); run_queue(-1);

        // Equal exponents
`ifdef FPCTL_EQEXP_BYPASS_EN
        lat_exp = 2;
`else
        lat_exp = 3;
`endif
        build_op(1'b0, 8'd0, 1'b1, NBITS'(22), 0, 0, 0); run_queue(-1);

        // Randomized operations, back-to-back where gap is zero
        lat_exp = -1;
        for (int i = 0; i < 200; i++) begin
            logic [EXPBITS-1:0] ed;
            logic [NBITS-1:0]   fi;
            case ($urandom_range(0, 3))
                0:       ed = '0;
                1:       ed = EXPBITS'($urandom_range(1, 30));
                2:       ed = EXPBITS'($urandom_range(MB + 1, MB + 3));
                default: ed = EXPBITS'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) fi = NBITS'($urandom);
            else                           fi = NBITS'($urandom_range(0, MB + 1));
            build_op(1'($urandom), ed, ($urandom_range(0, 9) != 0), fi,
                     $urandom_range(0, MAXROUND + 1), $urandom_range(0, 3),
                     $urandom_range(0, 2));
        end
        run_queue(-1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpadd_control_pipe.md
Name: fpadd_control_pipe

Overview:
Parametrised next-generation sequencing controller for the floating-point adder datapath. It steps one operation at a time through exponent alignment, normalisation and rounding, and drives the datapath's mux selects and shifter controls. Over the single-pass controller it adds:
- full parametrisation of exponent and mantissa widths
- a bounded rounding/renormalisation loop with an overflow error
- a ResultValid/ResultReady handshake with backpressure
- a saturated alignment shift
- an optional equal-exponent fast path

Parameters:
EXPBITS, 8, exponent field width
MANTISSABITS, 23, stored mantissa width (hidden bit excluded)
MAXROUND, 3, maximum rounding renormalisation passes before error
(local) NBITS = $clog2(MANTISSABITS+2), FFO index and left/right shift amount width
(local) NBITSE = $clog2(MANTISSABITS+3), alignment shift amount width

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
Go  in  1  start request, sampled only in IDLE
ExpSet  in  1  1 = exponent A >= exponent B
ExpDiff  in  EXPBITS  |expA - expB|
FFOValid  in  1  first-one finder found a set bit
FFOIndex  in  NBITS  bit position of the leading one in the sum
roundedMant  in  MANTISSABITS+2  rounder output; MSB set = carry-out
ResultReady  in  1  downstream accepts result
Busy  out  1  state != IDLE
SelExpMux  out  1  select larger exponent (= captured ExpSet)
SelSRMuxL, SelSRMuxG  out  1  route smaller/greater mantissa to the aligner
ShiftRightEnable  out  1  alignment shift active
ShiftRightAmount  out  NBITSE  alignment shift distance
ShiftAmount  out  NBITS  normalise shift distance
SREn, SLEn, NoShift  out  1  normaliser right / left / no shift
SelMuxR  out  1  feed rounded mantissa back to the normaliser
ResultValid  out  1  result on datapath is valid
FlagResult  out  1  zero result (FFOValid=0)
RoundErr  out  1  MAXROUND passes exhausted

Behaviour:
- States: IDLE, ALIGN, NORM, ROUND, DONE. The state register and the captured ExpSet_q/ExpDiff_q are flops.
- Outputs are decoded combinationally from state, captures and, in NORM/ROUND only, FFO/round inputs.
- Reset: async to IDLE; captures and round counter cleared; every output 0.
- IDLE:
  - Go=1: capture ExpSet, ExpDiff; go to ALIGN.
  - Go=0: stay.
- ALIGN (1 cycle):
  - SelExpMux = SelSRMuxL = ExpSet_q; SelSRMuxG = ~ExpSet_q.
  - ShiftRightEnable = (ExpDiff_q != 0).
  - ShiftRightAmount = min(ExpDiff_q, MANTISSABITS+2), saturated and never truncated.
  - Next state: NORM.
- NORM (1 cycle):
  - FFOValid=0: FlagResult=1; go to DONE.
  - FFOIndex = MANTISSABITS+1: SREn=1, ShiftAmount=1.
  - FFOIndex = MANTISSABITS: NoShift=1, ShiftAmount=0.
  - FFOIndex < MANTISSABITS: SLEn=1, ShiftAmount = MANTISSABITS - FFOIndex.
  - FFOIndex > MANTISSABITS+1 (illegal): RoundErr=1; go to DONE.
  - Otherwise go to ROUND with the counter cleared.
- ROUND:
  - roundedMant MSB=1 and count < MAXROUND: SREn=1, ShiftAmount=1, SelMuxR=1; count++; stay in ROUND.
  - MSB=1 and count = MAXROUND: RoundErr=1; go to DONE.
  - MSB=0: go to DONE (covers both 2'b01 and 2'b00 top bits).
- DONE:
  - ResultValid=1; FlagResult and RoundErr are registered and held while in DONE.
  - Leave to IDLE only when ResultReady=1; hold indefinitely under backpressure.
  - Go is ignored while in DONE.
- Latency, Go edge to ResultValid: 3 cycles plus rounding passes (IDLE→ALIGN→NORM→ROUND→DONE).
- Back-to-back: the earliest next Go is sampled in the cycle after the DONE handshake.
- Reset mid-operation: immediate abort to IDLE; no ResultValid.

Optional Feature:
Macro FPCTL_EQEXP_BYPASS_EN.
- Defined: in IDLE, Go=1 with ExpDiff=0 goes straight to NORM (ALIGN skipped, ShiftRightEnable never asserted), saving one cycle.
- Not defined: every operation passes through ALIGN.

Test Plan:
1. Reset 2 cycles; Go=1, ExpSet=1, ExpDiff=8'h55, FFOIndex=23, roundedMant top bits 2'b01 -> ALIGN shows ShiftRightAmount=25 (saturated), SelExpMux=1, NoShift=1 in NORM, ResultValid 3 cycles after Go.
2. ExpSet=0, ExpDiff=3, FFOIndex=20, roundedMant 2'b10 then 2'b01 -> SelSRMuxG=1 and ShiftRightAmount=3 in ALIGN; SLEn=1 with ShiftAmount=3 in NORM; one ROUND pass with SREn=1, SelMuxR=1; ResultValid 4 cycles after Go.
3. FFOValid=0 -> FlagResult=1, no ROUND state, ResultValid 2 cycles after Go; held with ResultReady=0 for 5 cycles, then clears one cycle after ResultReady=1.
4. roundedMant MSB held at 1 -> exactly 3 SelMuxR pulses, then RoundErr=1 with ResultValid; FFOIndex=30 -> RoundErr=1 straight from NORM.
5. Reset asserted mid-ROUND -> all outputs 0 asynchronously, Busy=0; the next Go runs normally.
6. With FPCTL_EQEXP_BYPASS_EN and ExpDiff=0 -> ShiftRightEnable never asserted, latency 2 cycles; without the macro -> 3 cycles.
